// File: rtl/pmem_arbiter.sv
// pmem_arbiter: two-port valid/ready arbiter that sequences fetch and LSU requests
// onto a single-cycle physical memory port, rejecting misaligned accesses up front.
module pmem_arbiter #(
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 64,
   parameter int PRIO_MODE = 0
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              m0_req_valid,
   output logic              m0_req_ready,
   input  logic [ADDR_W-1:0] m0_req_addr,
   output logic              m0_resp_valid,
   input  logic              m0_resp_ready,
   output logic [DATA_W-1:0] m0_resp_data,
   output logic              m0_resp_err,

   input  logic              m1_req_valid,
   output logic              m1_req_ready,
   input  logic              m1_req_wr,
   input  logic [ADDR_W-1:0] m1_req_addr,
   input  logic [DATA_W-1:0] m1_req_wdata,
   input  logic [7:0]        m1_req_len,
   output logic              m1_resp_valid,
   input  logic              m1_resp_ready,
   output logic [DATA_W-1:0] m1_resp_data,
   output logic              m1_resp_err,

   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic [7:0]        mem_wr_len
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              owner;      // 0: fetch port, 1: LSU port
   logic              last_gnt;   // port granted most recently
   logic              lat_wr;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [7:0]        lat_len;
   logic [DATA_W-1:0] resp_data;
   logic              resp_err;

   logic              gnt0;
   logic              gnt1;
   logic              req_legal;
   logic              resp_ready;

   function automatic logic m1_legal(input logic [ADDR_W-1:0] addr, input logic [7:0] len);
      case (len)
         8'd1:    return 1'b1;
         8'd2:    return addr[0] == 1'b0;
         8'd4:    return addr[1:0] == 2'b00;
         8'd8:    return addr[2:0] == 3'b000;
         default: return 1'b0;
      endcase
   endfunction

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state == IDLE && !rst) begin
         if (m0_req_valid && m1_req_valid) begin
            if (PRIO_MODE == 1 || !last_gnt) gnt1 = 1'b1;
            else                             gnt0 = 1'b1;
         end else begin
            gnt0 = m0_req_valid;
            gnt1 = m1_req_valid;
         end
      end
   end

   assign req_legal  = gnt1 ? m1_legal(m1_req_addr, m1_req_len) : (m0_req_addr[1:0] == 2'b00);
   assign resp_ready = owner ? m1_resp_ready : m0_resp_ready;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Outputs are forced low while rst is high, which also kills a write strobe in the reset cycle.
   always_comb begin
      state_nxt     = state;
      m0_req_ready  = 1'b0;
      m1_req_ready  = 1'b0;
      m0_resp_valid = 1'b0;
      m0_resp_data  = '0;
      m0_resp_err   = 1'b0;
      m1_resp_valid = 1'b0;
      m1_resp_data  = '0;
      m1_resp_err   = 1'b0;
      mem_rd_en     = 1'b0;
      mem_rd_addr   = '0;
      mem_wr_en     = 1'b0;
      mem_wr_addr   = '0;
      mem_wr_data   = '0;
      mem_wr_len    = '0;
      if (!rst) begin
         case (state)
            IDLE: begin
               m0_req_ready = gnt0;
               m1_req_ready = gnt1;
               if (gnt0 || gnt1) state_nxt = req_legal ? ACCESS : RESP;
            end
            ACCESS: begin
               if (lat_wr) begin
                  mem_wr_en   = 1'b1;
                  mem_wr_addr = lat_addr;
                  mem_wr_data = lat_wdata;
                  mem_wr_len  = lat_len;
               end else begin
                  mem_rd_en   = 1'b1;
                  mem_rd_addr = lat_addr;
               end
               state_nxt = RESP;
            end
            RESP: begin
               if (owner) begin
                  m1_resp_valid = 1'b1;
                  m1_resp_data  = resp_data;
                  m1_resp_err   = resp_err;
               end else begin
                  m0_resp_valid = 1'b1;
                  m0_resp_data  = resp_data;
                  m0_resp_err   = resp_err;
               end
               if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner     <= 1'b0;
         last_gnt  <= 1'b0;
         lat_wr    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_len   <= '0;
         resp_data <= '0;
         resp_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt0 || gnt1) begin
                  owner     <= gnt1;
                  last_gnt  <= gnt1;
                  lat_wr    <= gnt1 & m1_req_wr;
                  lat_addr  <= gnt1 ? m1_req_addr : m0_req_addr;
                  lat_wdata <= gnt1 ? m1_req_wdata : '0;
                  lat_len   <= gnt1 ? m1_req_len : 8'd4;
                  resp_data <= '0;
                  resp_err  <= !req_legal;
               end
            end
            ACCESS: begin
               if (!lat_wr) resp_data <= mem_rd_data;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed stimulus for pmem_arbiter with a transaction-level model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_pmem_arbiter;
   localparam int ADDR_W    = 64;
   localparam int DATA_W    = 64;
   localparam int PRIO_MODE = 0;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              m0_req_valid = 1'b0;
   logic              m0_req_ready;
   logic [ADDR_W-1:0] m0_req_addr = '0;
   logic              m0_resp_valid;
   logic              m0_resp_ready = 1'b1;
   logic [DATA_W-1:0] m0_resp_data;
   logic              m0_resp_err;
   logic              m1_req_valid = 1'b0;
   logic              m1_req_ready;
   logic              m1_req_wr = 1'b0;
   logic [ADDR_W-1:0] m1_req_addr = '0;
   logic [DATA_W-1:0] m1_req_wdata = '0;
   logic [7:0]        m1_req_len = 8'd0;
   logic              m1_resp_valid;
   logic              m1_resp_ready = 1'b1;
   logic [DATA_W-1:0] m1_resp_data;
   logic              m1_resp_err;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [DATA_W-1:0] mem_rd_data;
   logic              mem_wr_en;
   logic [ADDR_W-1:0] mem_wr_addr;
   logic [DATA_W-1:0] mem_wr_data;
   logic [7:0]        mem_wr_len;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRIO_MODE(PRIO_MODE)) dut (
      .clk(clk), .rst(rst),
      .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
      .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready),
      .m0_resp_data(m0_resp_data), .m0_resp_err(m0_resp_err),
      .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_wr(m1_req_wr),
      .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata), .m1_req_len(m1_req_len),
      .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready),
      .m1_resp_data(m1_resp_data), .m1_resp_err(m1_resp_err),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .mem_wr_len(mem_wr_len)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Sixteen-word bench memory; unwritten words return a fixed per-index pattern.
   logic [63:0] wmem [16];
   bit   [15:0] wvalid = '0;

   function automatic logic [63:0] mem_word(input logic [63:0] a);
      logic [3:0] idx;
      idx = a[6:3];
      if (wvalid[idx]) return wmem[idx];
      if (idx == 4'd0) return 64'hDEADBEEF_00000013;
      return {32'h0BAD0000 | 32'(idx), 32'h13579BDF ^ 32'(idx)};
   endfunction

   function automatic logic [63:0] len_mask(input logic [7:0] len);
      if (len >= 8'd8) return '1;
      return (64'd1 << (8 * int'(len))) - 64'd1;
   endfunction

   always_comb mem_rd_data = mem_rd_en ? mem_word(mem_rd_addr) : '0;

   always @(posedge clk) begin
      if (mem_wr_en) begin
         wmem[mem_wr_addr[6:3]]   <= mem_wr_data & len_mask(mem_wr_len);
         wvalid[mem_wr_addr[6:3]] <= 1'b1;
      end
   end

   // Transaction-level model: one outstanding request, tracked by its acceptance cycle.
   int          cyc = 0;
   int          acc_cyc = 0;
   bit          busy = 1'b0;
   bit          rr_last = 1'b0;
   bit          t_port;
   bit          t_legal;
   bit          t_wr;
   logic [63:0] t_addr;
   logic [63:0] t_wdata;
   logic [63:0] t_data;
   logic [7:0]  t_len;

   always @(negedge clk) begin
      int age;
      bit exp0;
      bit exp1;
      cyc++;
      if (rst) begin
         check("rst_ctrl_zero", 64'({m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid,
                                     m0_resp_err, m1_resp_err, mem_rd_en, mem_wr_en}), 64'd0);
         check("rst_data_zero", m0_resp_data | m1_resp_data | mem_wr_data | mem_rd_addr |
                                mem_wr_addr | 64'(mem_wr_len), 64'd0);
         busy    = 1'b0;
         rr_last = 1'b0;
      end else if (!busy) begin
         exp0 = 1'b0;
         exp1 = 1'b0;
         if (m0_req_valid && m1_req_valid) begin
            if (PRIO_MODE == 1 || rr_last == 1'b0) exp1 = 1'b1;
            else                                   exp0 = 1'b1;
         end else begin
            exp0 = m0_req_valid;
            exp1 = m1_req_valid;
         end
         check("idle_ready", 64'({m0_req_ready, m1_req_ready}), 64'({exp0, exp1}));
         check("idle_quiet", 64'({mem_rd_en, mem_wr_en, m0_resp_valid, m1_resp_valid}), 64'd0);
         if (exp0 || exp1) begin
            busy    = 1'b1;
            acc_cyc = cyc;
            t_port  = exp1;
            rr_last = exp1;
            if (exp1) begin
               t_wr    = m1_req_wr;
               t_addr  = m1_req_addr;
               t_wdata = m1_req_wdata;
               t_len   = m1_req_len;
               t_legal = (t_len == 1 || t_len == 2 || t_len == 4 || t_len == 8) &&
                         (t_addr % 64'(t_len) == 64'd0);
            end else begin
               t_wr    = 1'b0;
               t_addr  = m0_req_addr;
               t_wdata = '0;
               t_len   = 8'd4;
               t_legal = (t_addr % 64'd4 == 64'd0);
            end
            t_data = (t_legal && !t_wr) ? mem_word(t_addr) : 64'd0;
         end
      end else begin
         age = cyc - acc_cyc;
         check("busy_ready", 64'({m0_req_ready, m1_req_ready}), 64'd0);
         if (t_legal && age == 1) begin
            check("access_strobe", 64'({mem_rd_en, mem_wr_en}), t_wr ? 64'd1 : 64'd2);
            if (t_wr) begin
               check("wr_addr", mem_wr_addr, t_addr);
               check("wr_data", mem_wr_data, t_wdata);
               check("wr_len", 64'(mem_wr_len), 64'(t_len));
            end else begin
               check("rd_addr", mem_rd_addr, t_addr);
            end
            check("access_no_resp", 64'({m0_resp_valid, m1_resp_valid}), 64'd0);
         end else begin
            check("resp_no_strobe", 64'({mem_rd_en, mem_wr_en}), 64'd0);
            check("resp_valid", 64'({m0_resp_valid, m1_resp_valid}), t_port ? 64'd1 : 64'd2);
            check("resp_err", 64'(t_port ? m1_resp_err : m0_resp_err), 64'(!t_legal));
            check("resp_data", t_port ? m1_resp_data : m0_resp_data, t_data);
            if (t_port ? m1_resp_ready : m0_resp_ready) busy = 1'b0;
         end
      end
   end

   task automatic wait_accept(input bit port);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = port ? m1_req_ready : m0_req_ready;
      end
      check(port ? "m1_accept" : "m0_accept", 64'(got), 64'd1);
      @(posedge clk);
      #1;
      if (port) m1_req_valid = 1'b0;
      else      m0_req_valid = 1'b0;
   endtask

   task automatic send_m1(input bit wr, input logic [63:0] a, input logic [63:0] d,
                          input logic [7:0] l);
      @(posedge clk);
      #1;
      m1_req_valid = 1'b1;
      m1_req_wr    = wr;
      m1_req_addr  = a;
      m1_req_wdata = d;
      m1_req_len   = l;
      wait_accept(1'b1);
   endtask

   task automatic send_m0(input logic [63:0] a);
      @(posedge clk);
      #1;
      m0_req_valid = 1'b1;
      m0_req_addr  = a;
      wait_accept(1'b0);
   endtask

   // Latency counts negedges after the accepting edge's following cycle started.
   task automatic wait_resp(input bit port, input int exp_lat, input bit exp_err,
                            input logic [63:0] exp_data);
      bit seen;
      int lat;
      seen = 1'b0;
      lat  = 0;
      for (int i = 1; i <= 8 && !seen; i++) begin
         @(negedge clk);
         if (port ? m1_resp_valid : m0_resp_valid) begin
            seen = 1'b1;
            lat  = i;
         end
      end
      check("resp_seen", 64'(seen), 64'd1);
      if (seen) begin
         check("resp_latency", 64'(lat), 64'(exp_lat));
         check("resp_err_lit", 64'(port ? m1_resp_err : m0_resp_err), 64'(exp_err));
         check("resp_data_lit", port ? m1_resp_data : m0_resp_data, exp_data);
      end
   endtask

   typedef struct {
      logic [63:0] addr;
      logic [7:0]  len;
      bit          err;
      logic [63:0] data;
   } lsu_vec_t;

   lsu_vec_t vecs [6];
   bit       exp_order [4];
   bit       found;
   bit       who;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{64'h80000003, 8'd4, 1'b1, 64'd0};
      vecs[1] = '{64'h80000000, 8'd3, 1'b1, 64'd0};
      vecs[2] = '{64'h80000006, 8'd2, 1'b0, 64'hDEADBEEF_00000013};
      vecs[3] = '{64'h80000007, 8'd1, 1'b0, 64'hDEADBEEF_00000013};
      vecs[4] = '{64'h80000004, 8'd8, 1'b1, 64'd0};
      vecs[5] = '{64'h80000004, 8'd4, 1'b0, 64'hDEADBEEF_00000013};
      exp_order[0] = 1'b1;
      exp_order[1] = 1'b0;
      exp_order[2] = 1'b1;
      exp_order[3] = 1'b0;

      // Reset: a pending request must not be accepted.
      m1_req_valid = 1'b1;
      m1_req_len   = 8'd8;
      @(negedge clk);
      check("reset_ready_gated", 64'(m1_req_ready), 64'd0);
      @(posedge clk);
      #1;
      m1_req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_quiet", 64'({m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid,
                                     mem_rd_en, mem_wr_en}), 64'd0);

      // Store: single write strobe, empty response.
      send_m1(1'b1, 64'h80000008, 64'h11223344_55667788, 8'd8);
      @(negedge clk);
      check("st_wr_en", 64'({mem_wr_en, mem_rd_en}), 64'd2);
      check("st_wr_addr", mem_wr_addr, 64'h80000008);
      check("st_wr_data", mem_wr_data, 64'h11223344_55667788);
      check("st_wr_len", 64'(mem_wr_len), 64'd8);
      wait_resp(1'b1, 1, 1'b0, 64'd0);

      // Fetch: read strobe then raw word.
      send_m0(64'h80000004);
      @(negedge clk);
      check("fe_rd_en", 64'({mem_rd_en, mem_wr_en}), 64'd2);
      check("fe_rd_addr", mem_rd_addr, 64'h80000004);
      wait_resp(1'b0, 1, 1'b0, 64'hDEADBEEF_00000013);

      // Misaligned fetch: error response one cycle after acceptance.
      send_m0(64'h80000002);
      wait_resp(1'b0, 1, 1'b1, 64'd0);

      // Round-robin with both ports held valid, starting from reset.
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst          = 1'b0;
      m0_req_valid = 1'b1;
      m0_req_addr  = 64'h80000010;
      m1_req_valid = 1'b1;
      m1_req_wr    = 1'b0;
      m1_req_addr  = 64'h80000018;
      m1_req_len   = 8'd8;
      for (int k = 0; k < 4; k++) begin
         found = 1'b0;
         who   = 1'b0;
         for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (m1_req_ready)      begin found = 1'b1; who = 1'b1; end
            else if (m0_req_ready) begin found = 1'b1; who = 1'b0; end
         end
         check("arb_found", 64'(found), 64'd1);
         check("arb_order", 64'(who), 64'(exp_order[k]));
      end
      @(posedge clk);
      #1;
      m0_req_valid = 1'b0;
      m1_req_valid = 1'b0;

      // LSU legality table.
      for (int v = 0; v < 6; v++) begin
         send_m1(1'b0, vecs[v].addr, 64'd0, vecs[v].len);
         wait_resp(1'b1, vecs[v].err ? 1 : 2, vecs[v].err, vecs[v].data);
         if (vecs[v].err) check("err_no_strobe", 64'({mem_rd_en, mem_wr_en}), 64'd0);
      end

      // Response back-pressure: held response, fetch waits.
      @(posedge clk);
      #1;
      m1_resp_ready = 1'b0;
      send_m1(1'b0, 64'h80000008, 64'd0, 8'd8);
      m0_req_valid = 1'b1;
      m0_req_addr  = 64'h80000020;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_valid", 64'(m1_resp_valid), 64'd1);
         check("hold_data", m1_resp_data, 64'h11223344_55667788);
         check("hold_m0_blocked", 64'(m0_req_ready), 64'd0);
      end
      @(posedge clk);
      #1;
      m1_resp_ready = 1'b1;
      wait_accept(1'b0);
      wait_resp(1'b0, 2, 1'b0, 64'h0BAD0004_13579BDB);

      // Reset during the access cycle of a store.
      send_m1(1'b1, 64'h80000028, 64'h00000000_CAFEF00D, 8'd4);
      rst = 1'b1;
      @(negedge clk);
      check("rst_access_wr_en", 64'(mem_wr_en), 64'd0);
      check("rst_access_resp", 64'(m1_resp_valid), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_after_quiet", 64'({m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid,
                                    mem_rd_en, mem_wr_en, m1_resp_err}), 64'd0);
      check("rst_after_data", m1_resp_data | mem_wr_data, 64'd0);
      check("rst_no_commit", 64'(wvalid[5]), 64'd0);
      repeat (3) @(negedge clk);
      check("rst_no_late_resp", 64'(m1_resp_valid), 64'd0);

      // Recovery: load back the earlier store.
      send_m1(1'b0, 64'h80000008, 64'd0, 8'd8);
      wait_resp(1'b1, 2, 1'b0, 64'h11223344_55667788);

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
